// File: rtl/ps2_scan_decoder.sv
// ps2_scan_decoder: receives PS/2 device-to-host frames, checks framing and parity,
// strips E0/F0 prefixes, swallows the E1 Pause sequence and emits make/break events.
module ps2_scan_decoder #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [8:0] last_change,
  output logic       keydown,
  output logic       ready,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic {IDLE, RECV} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_q, cs_d, ds_q, ds_d;
  logic prev_q, prev_d;
  logic s_clk, s_data, fall;
  logic [3:0] cnt_q, cnt_d;
  logic [8:0] sh_q, sh_d;
  logic [TW-1:0] to_q, to_d;
  logic chk_q, chk_d, ok_q, ok_d;
  logic [7:0] byte_q, byte_d;
  logic ext_q, ext_d, brk_q, brk_d;
  logic [2:0] skip_q, skip_d;
  logic [8:0] last_change_q, last_change_d;
  logic keydown_q, keydown_d, ready_q, ready_d, frame_err_q, frame_err_d;

  assign s_clk  = cs_q[SYNC_STAGES-1];
  assign s_data = ds_q[SYNC_STAGES-1];
  assign fall   = prev_q & ~s_clk;
  assign cs_d   = {cs_q[SYNC_STAGES-2:0], ps2_clk};
  assign ds_d   = {ds_q[SYNC_STAGES-2:0], ps2_data};
  assign prev_d = s_clk;

  // Frame reception: cnt counts bits already taken, start bit included.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    to_d    = '0;
    chk_d   = 1'b0;
    ok_d    = ok_q;
    byte_d  = byte_q;
    if (state_q == IDLE) begin
      if (fall && !s_data) begin
        state_d = RECV;
        cnt_d   = 4'd1;
      end
    end else if (fall) begin
      if (cnt_q == 4'd10) begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        chk_d   = 1'b1;
        ok_d    = (^sh_q) & s_data;
        byte_d  = sh_q[7:0];
      end else begin
        sh_d  = {s_data, sh_q[8:1]};
        cnt_d = cnt_q + 4'd1;
      end
    end else if (to_q == TW'(TIMEOUT_CYCLES)) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
    end else begin
      to_d = to_q + 1'b1;
    end
  end

  always_comb begin
    ext_d         = ext_q;
    brk_d         = brk_q;
    skip_d        = skip_q;
    last_change_d = last_change_q;
    keydown_d     = keydown_q;
    ready_d       = 1'b0;
    frame_err_d   = 1'b0;
    if (chk_q) begin
      if (!ok_q) begin
        frame_err_d = 1'b1;
        ext_d       = 1'b0;
        brk_d       = 1'b0;
      end else if (skip_q != 3'd0) begin
        skip_d = skip_q - 3'd1;
      end else if (byte_q == 8'hE1) begin
        skip_d = 3'd7;
      end else if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else begin
        last_change_d = {ext_q, byte_q};
        keydown_d     = ~brk_q;
        ready_d       = 1'b1;
        ext_d         = 1'b0;
        brk_d         = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_q          <= '1;
      ds_q          <= '1;
      prev_q        <= 1'b1;
      state_q       <= IDLE;
      cnt_q         <= '0;
      sh_q          <= '0;
      to_q          <= '0;
      chk_q         <= 1'b0;
      ok_q          <= 1'b0;
      byte_q        <= '0;
      ext_q         <= 1'b0;
      brk_q         <= 1'b0;
      skip_q        <= '0;
      last_change_q <= '0;
      keydown_q     <= 1'b0;
      ready_q       <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      cs_q          <= cs_d;
      ds_q          <= ds_d;
      prev_q        <= prev_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sh_q          <= sh_d;
      to_q          <= to_d;
      chk_q         <= chk_d;
      ok_q          <= ok_d;
      byte_q        <= byte_d;
      ext_q         <= ext_d;
      brk_q         <= brk_d;
      skip_q        <= skip_d;
      last_change_q <= last_change_d;
      keydown_q     <= keydown_d;
      ready_q       <= ready_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign last_change = last_change_q;
  assign keydown     = keydown_q;
  assign ready       = ready_q;
  assign frame_err   = frame_err_q;
endmodule

// File: tb/tb_ps2_scan_decoder.sv
// tb_ps2_scan_decoder: directed plan plus random byte stream against a keyboard event model.
module tb_ps2_scan_decoder;
  localparam int TO = 300;
  logic clk = 1'b0;
  logic rst, ps2_clk, ps2_data;
  logic [8:0] last_change;
  logic keydown, ready, frame_err;
  int checks = 0, errors = 0, ready_cnt = 0, err_cnt = 0;
  bit both_seen = 1'b0;
  int m_skip = 0, m_ready = 0, m_err = 0;
  bit m_ext = 1'b0, m_brk = 1'b0, m_kd = 1'b0;
  logic [8:0] m_lc = '0;
  bit exp_ready, exp_err;

  always #5 clk = ~clk;

  ps2_scan_decoder #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .last_change(last_change), .keydown(keydown), .ready(ready), .frame_err(frame_err)
  );

  always @(negedge clk) begin
    if (ready) ready_cnt++;
    if (frame_err) err_cnt++;
    if (ready && frame_err) both_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_skip = 0; m_ext = 1'b0; m_brk = 1'b0; m_lc = '0; m_kd = 1'b0;
  endtask

  // Keyboard event rules: a bad frame drops prefixes, Pause eats its 7 trailing bytes.
  task automatic model_byte(input logic [7:0] b, input bit ok);
    exp_ready = 1'b0;
    exp_err   = 1'b0;
    if (!ok) begin
      exp_err = 1'b1; m_err++; m_ext = 1'b0; m_brk = 1'b0;
    end else if (m_skip > 0) m_skip--;
    else if (b == 8'hE1) m_skip = 7;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else begin
      exp_ready = 1'b1; m_ready++;
      m_lc = {m_ext, b}; m_kd = !m_brk;
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad, input int nbits);
    logic [10:0] f;
    logic par;
    bit early;
    par = ($countones(b) % 2 == 0);
    if (bad) par = !par;
    f = {1'b1, par, b, 1'b0};
    if (nbits == 11) model_byte(b, !bad);
    for (int i = 0; i < nbits; i++) begin
      repeat (5) @(negedge clk);
      ps2_data = f[i];
      repeat (5) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) begin
        early = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          if (ready || frame_err) early = 1'b1;
        end
        chk("early_pulse", 32'(early), 0);
        @(negedge clk);
        chk("ready", 32'(ready), 32'(exp_ready));
        chk("frame_err", 32'(frame_err), 32'(exp_err));
        chk("last_change", 32'(last_change), 32'(m_lc));
        chk("keydown", 32'(keydown), 32'(m_kd));
        repeat (6) @(negedge clk);
      end else repeat (10) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (5) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  initial begin
    logic [7:0] pause_seq [8];
    int start_cnt;
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_last_change", 32'(last_change), 0);
    chk("rst_flags", 32'({keydown, ready, frame_err}), 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    send_frame(8'h1C, 0, 11);
    send_frame(8'hF0, 0, 11);
    send_frame(8'h1C, 0, 11);
    send_frame(8'hE0, 0, 11);
    send_frame(8'hF0, 0, 11);
    send_frame(8'h75, 0, 11);
    send_frame(8'hE0, 0, 11);
    send_frame(8'h75, 0, 11);
    send_frame(8'h16, 1, 11);
    send_frame(8'h16, 0, 11);

    start_cnt = ready_cnt + err_cnt;
    send_frame(8'h26, 0, 5);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (TO + 10) @(negedge clk);
    chk("timeout_silent", 32'(ready_cnt + err_cnt), 32'(start_cnt));
    send_frame(8'h26, 0, 11);

    start_cnt = ready_cnt;
    for (int i = 0; i < 8; i++) send_frame(pause_seq[i], 0, 11);
    send_frame(8'h4A, 0, 11);
    chk("pause_one_ready", 32'(ready_cnt - start_cnt), 1);

    send_frame(8'hF0, 0, 11);
    send_frame(8'h1E, 0, 4);
    repeat (5) @(negedge clk);
    ps2_data = 1'b0;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("midframe_rst_last_change", 32'(last_change), 0);
    chk("midframe_rst_flags", 32'({keydown, ready, frame_err}), 0);
    model_reset();
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h1E, 0, 11);

    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 4) send_frame(8'hE0, 0, 11);
      else if (r < 8) send_frame(8'hF0, 0, 11);
      else if (r < 10) send_frame(8'($urandom_range(0, 255)), 1, 11);
      else if (r == 10) send_frame(8'hE1, 0, 11);
      else send_frame(8'($urandom_range(1, 8'h83)), 0, 11);
    end

    repeat (10) @(negedge clk);
    chk("ready_total", 32'(ready_cnt), 32'(m_ready));
    chk("err_total", 32'(err_cnt), 32'(m_err));
    chk("ready_err_exclusive", 32'(both_seen), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
